lsu_seq: RTL
============

Name: lsu_seq

Overview:
- Multi-cycle load/store sequencer between the core's decode/execute stage and a data memory with a req/ack handshake.
- Takes the decoder's load, store and lsu-op controls plus the effective address and store data.
- Issues one word-aligned memory transaction with byte enables and holds the core via a stall until the access completes.
- Returns extended load data, or a one-cycle fault when the access is misaligned, illegal or timed out.

Parameters:
- TIMEOUT_CYCLES, 255: maximum number of REQ-state cycles without ack before the access is aborted; legal range 1..65535.
- CNT_WIDTH, 16: width of the timeout counter.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_load  in  1  decoder load control
- i_store  in  1  decoder store control
- i_lsu_op  in  3  funct3 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_addr  in  32  effective byte address
- i_wdata  in  32  store source data
- o_stall  out  1  core must hold PC and pipeline
- o_rdata  out  32  extended load result
- o_rdata_valid  out  1  one-cycle result strobe for a successful load
- o_fault  out  2  00 none, 01 misaligned, 10 timeout, 11 illegal
- o_mem_req  out  1  memory request
- o_mem_we  out  1  1 = write
- o_mem_addr  out  32  word address, bits [1:0] = 00
- o_mem_be  out  4  byte enables
- o_mem_wdata  out  32  lane-replicated store data
- i_mem_ack  in  1  memory completion
- i_mem_rdata  in  32  read word, valid with ack

Behaviour:
- Clocking and reset: single clock domain. i_rst is synchronous and active-high.
- Reset: state=IDLE; all registered outputs (o_mem_*, o_rdata, o_rdata_valid, o_fault) = 0; timeout counter = 0.
- Reset mid-transaction: o_mem_req is low from the cycle after reset is sampled. An ack arriving in IDLE is ignored.
- The FSM has three states: IDLE, REQ and DONE.

IDLE
- An access is present when i_load or i_store is 1.
- o_stall = access present (combinational).
- Illegal access: i_load and i_store both set; lsu_op is 011, 110 or 111; or a store with lsu_op[2]=1.
  - Go to DONE with fault 11. No memory request is issued.
- Misaligned access (checked only when the access is legal): H/HU with addr[0]=1, or W with addr[1:0]!=00.
  - Go to DONE with fault 01. No memory request is issued.
- Legal, aligned access:
  - Latch op and addr[1:0].
  - Drive o_mem_addr = {addr[31:2], 00} and o_mem_we = store.
  - Set be and wdata per the lane rules below.
  - Go to REQ.

REQ
- o_mem_req=1 and o_stall=1. o_mem_* are held stable.
- The counter increments each cycle.
- If i_mem_ack=1:
  - For a load, capture the extended load data into o_rdata.
  - Go to DONE with fault 00.
- Else, if counter == TIMEOUT_CYCLES-1:
  - Go to DONE with fault 10 and o_rdata = 0.
- Ack in the same cycle as timeout: ack wins.
- o_mem_req is deasserted on entry to DONE.

DONE
- Lasts exactly one cycle. o_stall=0, so the core advances at the end of this cycle.
- o_rdata_valid = 1 only for a successful load. o_fault carries the cause.
- Access inputs are ignored in this cycle (they still belong to the retiring instruction).
- Counter clears. Next state is IDLE.

Lanes (k = addr[1:0])
- SB: be = 0001 << k; wdata = 4 copies of wdata[7:0].
- SH: be = 0011 (k=0) or 1100 (k=2); wdata = 2 copies of wdata[15:0].
- SW: be = 1111; wdata passed through.
- Loads: be = 1111.
- B/BU extract rdata byte k; H/HU extract halfword k[1]. B/H sign-extend, BU/HU zero-extend.

Latency
- Minimum 3 cycles from the access being presented to the core advancing: IDLE, one REQ cycle, DONE.
- The stall covers the IDLE and REQ cycles.
- Fault paths take 2 cycles (IDLE, DONE).

Test Plan:
- LW addr 0x100, ack 3 cycles after req rises, rdata 0xDEADBEEF -> mem_addr 0x100, be 1111, req high 3 cycles, o_rdata 0xDEADBEEF, valid for 1 cycle, stall released in DONE only.
- LB addr 0x203, rdata 0x80123456 -> o_rdata 0xFFFFFF80; LBU with the same stimulus -> 0x00000080; LHU addr 0x202 -> 0x00008012.
- SH addr 0x3A, wdata 0x0000ABCD, immediate ack -> mem_addr 0x38, be 1100, mem_wdata 0xABCDABCD, we=1, o_rdata_valid=0.
- LW addr 0x102 -> o_mem_req never asserts, fault 01 for 1 cycle; load+store both set -> fault 11; SB with lsu_op 100 -> fault 11.
- TIMEOUT_CYCLES=4, no ack -> req high exactly 4 cycles, then fault 10, o_rdata 0; repeat with ack in the 4th cycle -> fault 00, data valid.
- Reset asserted during REQ -> req low the next cycle, state IDLE; a late ack is ignored; the next LW completes normally.

Source files
------------

// File: rtl/lsu_seq.sv
// Load/store sequencer: turns one decoded load/store into a single word-aligned
// req/ack memory transaction, stalls the core until it completes, and returns
// extended load data or a one-cycle fault code.
module lsu_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_store,
    input  logic [2:0]  i_lsu_op,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic [31:0] o_rdata,
    output logic        o_rdata_valid,
    output logic [1:0]  o_fault,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

    // Last REQ-state count value before the access is abandoned.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [1:0]           state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [2:0]           op_q;
    logic [1:0]           off_q;

    logic        access;
    logic        illegal;
    logic        misaligned;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] ld_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Decode of the access currently presented by the core.
    always_comb begin
        access     = i_load | i_store;
        illegal    = (i_load & i_store) | (i_lsu_op == 3'b011) | (i_lsu_op[2:1] == 2'b11) |
                     (i_store & i_lsu_op[2]);
        misaligned = ((i_lsu_op[1:0] == 2'b01) & i_addr[0]) |
                     ((i_lsu_op[1:0] == 2'b10) & (i_addr[1:0] != 2'b00));
    end

    // Store lane steering: replicate data across lanes, enable only the target bytes.
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = i_wdata;
        if (i_store) begin
            case (i_lsu_op[1:0])
                2'b00: begin
                    be_new    = 4'b0001 << i_addr[1:0];
                    wdata_new = {4{i_wdata[7:0]}};
                end
                2'b01: begin
                    be_new    = i_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_new = {2{i_wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // Load extraction from the returned word using the latched size and offset.
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = i_mem_rdata[7:0];
            2'd1:    ld_byte = i_mem_rdata[15:8];
            2'd2:    ld_byte = i_mem_rdata[23:16];
            default: ld_byte = i_mem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (op_q[1:0])
            2'b00:   ld_ext = op_q[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = op_q[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_ext = i_mem_rdata;
        endcase
    end

    // Core is held while an access waits in IDLE and for every REQ cycle.
    always_comb begin
        o_stall = ((state_q == S_IDLE) & access) | (state_q == S_REQ);
    end

    // Sequencer state, memory interface and result registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            op_q          <= 3'b000;
            off_q         <= 2'b00;
            o_rdata       <= 32'b0;
            o_rdata_valid <= 1'b0;
            o_fault       <= FAULT_NONE;
            o_mem_req     <= 1'b0;
            o_mem_we      <= 1'b0;
            o_mem_addr    <= 32'b0;
            o_mem_be      <= 4'b0;
            o_mem_wdata   <= 32'b0;
        end else begin
            // Result strobes are single-cycle; only the DONE entry sets them.
            o_rdata_valid <= 1'b0;
            o_fault       <= FAULT_NONE;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (access) begin
                        if (illegal) begin
                            o_fault <= FAULT_ILLEGAL;
                            state_q <= S_DONE;
                        end else if (misaligned) begin
                            o_fault <= FAULT_MISALIGN;
                            state_q <= S_DONE;
                        end else begin
                            op_q        <= i_lsu_op;
                            off_q       <= i_addr[1:0];
                            o_mem_addr  <= {i_addr[31:2], 2'b00};
                            o_mem_we    <= i_store;
                            o_mem_be    <= be_new;
                            o_mem_wdata <= wdata_new;
                            o_mem_req   <= 1'b1;
                            state_q     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    cnt_q <= cnt_q + 1'b1;
                    // Ack takes priority over a timeout in the same cycle.
                    if (i_mem_ack) begin
                        o_mem_req <= 1'b0;
                        state_q   <= S_DONE;
                        if (!o_mem_we) begin
                            o_rdata       <= ld_ext;
                            o_rdata_valid <= 1'b1;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        o_mem_req <= 1'b0;
                        o_fault   <= FAULT_TIMEOUT;
                        o_rdata   <= 32'b0;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
